instr_decoder_alu_stage: RTL and testbench

Registered decode stage for the RISC-V integer ALU instruction class: OP (R-type, opcode 0110011) and OP-IMM (I-type, opcode 0010011).
- Accepts instruction + PC on a valid/ready input, emits decoded fields on a valid/ready output.
- 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Sits between fetch and the register-read/ALU issue stage; successor to the combinational R-type decoder.

---
 rtl/instr_decoder_alu_stage.sv | 195 +++++++++++++++++++
 tb/tb_instr_decoder_alu_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder_alu_stage.sv
// Registered decode stage for RISC-V OP / OP-IMM instructions.
// A two-entry skid buffer (main + skid) keeps in_ready registered.
// Optional: define DECODER_ILLEGAL_HOLD_EN to make an illegal entry stall in
// the main register until flush. It is then neither drained nor counted.
module instr_decoder_alu_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_use_imm,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    decode_count
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [ALU_OP_W-1:0] ALU_NOP  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(10);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     imm;
    logic                use_imm;
    logic                illegal;
  } entry_t;

  entry_t           main_q, main_d, skid_q, skid_d, dec;
  logic             main_valid, main_valid_d, skid_valid, skid_valid_d;
  logic             in_ready_d, accept, drain;
  logic [CNT_W-1:0] count_d;

  // Decode one instruction word into a buffer entry
  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t              e;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [ALU_OP_W-1:0] op;
    logic                legal;
    logic                shamt_ok;
    e        = '0;
    e.pc     = pc;
    e.rd     = instr[11:7];
    e.rs1    = instr[19:15];
    e.rs2    = instr[24:20];
    f3       = instr[14:12];
    f7       = instr[31:25];
    legal    = 1'b0;
    // Bit 25 belongs to the shift amount only on a 64-bit datapath
    shamt_ok = (XLEN == 64) || !instr[25];
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    case (instr[6:0])
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal = 1'b1;
          op    = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        e.rs2     = 5'd0;
        e.use_imm = 1'b1;
        e.imm     = XLEN'($signed(instr[31:20]));
        legal     = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          e.imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
          if (f3 == 3'b001) begin
            legal = (instr[31:26] == 6'b000000) && shamt_ok;
          end else if (instr[31:26] == 6'b000000) begin
            legal = shamt_ok;
          end else if (instr[31:26] == 6'b010000) begin
            op    = ALU_SRA;
            legal = shamt_ok;
          end else begin
            legal = 1'b0;
          end
        end
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      e.alu_op = op;
    end else begin
      e.alu_op  = ALU_NOP;
      e.use_imm = 1'b0;
      e.imm     = '0;
      e.rs2     = instr[24:20];
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Next-state for the skid buffer, ready and counter
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    dec          = decode(in_instr, in_pc);
    accept       = in_valid && in_ready && !flush;
`ifdef DECODER_ILLEGAL_HOLD_EN
    drain        = main_valid && out_ready && !main_q.illegal;
`else
    drain        = main_valid && out_ready;
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
    count_d    = drain ? decode_count + CNT_W'(1) : decode_count;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      in_ready     <= 1'b1;
      decode_count <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid   <= main_valid_d;
      skid_valid   <= skid_valid_d;
      in_ready     <= in_ready_d;
      decode_count <= count_d;
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_q.pc;
  assign out_alu_op  = main_q.alu_op;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_imm     = main_q.imm;
  assign out_use_imm = main_q.use_imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decoder_alu_stage.sv
// Self-checking bench for instr_decoder_alu_stage (XLEN=32, CNT_W=4).
module tb_instr_decoder_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [3:0]  out_alu_op, decode_count;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_use_imm, out_illegal;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_cnt;

  instr_decoder_alu_stage #(.XLEN(32), .ALU_OP_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_illegal(out_illegal),
    .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int imm);
    logic [31:0] w;
    w = (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
    return w;
  endfunction

  // Push one vector through: accept, inspect, stall, then drain
  task automatic run_vec(input int i);
    logic [31:0] pc;
    pc       = 32'h100 + 32'(i * 4);
    in_valid = 1'b1;
    in_instr = vecs[i].instr;
    in_pc    = pc;
    chk($sformatf("v%0d_in_ready", i), in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk($sformatf("v%0d_valid", i), out_valid, 1);
    chk($sformatf("v%0d_pc", i), out_pc, pc);
    chk($sformatf("v%0d_op", i), out_alu_op, vecs[i].op);
    chk($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
    chk($sformatf("v%0d_rs1", i), out_rs1, vecs[i].rs1);
    chk($sformatf("v%0d_use_imm", i), out_use_imm, vecs[i].use_imm);
    chk($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
    if (!vecs[i].ill) begin
      chk($sformatf("v%0d_rs2", i), out_rs2, vecs[i].rs2);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
    end
    tick();
    chk($sformatf("v%0d_stall_valid", i), out_valid, 1);
    chk($sformatf("v%0d_stall_pc", i), out_pc, pc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef DECODER_ILLEGAL_HOLD_EN
    if (vecs[i].ill) begin
      chk($sformatf("v%0d_held", i), out_valid, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end else begin
      exp_cnt++;
    end
`else
    exp_cnt++;
`endif
    chk($sformatf("v%0d_drained", i), out_valid, 0);
    chk($sformatf("v%0d_count", i), decode_count, exp_cnt);
  endtask

  initial begin
    int   sent, got;
    logic saw_stall;

    //         instr         op  rd  rs1 rs2 imm           use ill
    vecs[0]  = '{32'h002081B3, 1,  3,  1,  2, 32'h0,        0, 0}; // add x3,x1,x2
    vecs[1]  = '{32'hFFF00293, 1,  5,  0,  0, 32'hFFFFFFFF, 1, 0}; // addi x5,x0,-1
    vecs[2]  = '{32'h4040D093, 8,  1,  1,  0, 32'h4,        1, 0}; // srai x1,x1,4
    vecs[3]  = '{32'h402081B3, 2,  3,  1,  2, 32'h0,        0, 0}; // sub
    vecs[4]  = '{32'h422081B3, 0,  3,  1,  0, 32'h0,        0, 1}; // bad funct7
    vecs[5]  = '{32'h00012083, 0,  1,  2,  0, 32'h0,        0, 1}; // load opcode
    vecs[6]  = '{32'h00629233, 3,  4,  5,  6, 32'h0,        0, 0}; // sll x4,x5,x6
    vecs[7]  = '{32'h409453B3, 8,  7,  8,  9, 32'h0,        0, 0}; // sra x7,x8,x9
    vecs[8]  = '{32'h00C5F533, 10, 10, 11, 12, 32'h0,       0, 0}; // and
    vecs[9]  = '{32'h7FF1B113, 5,  2,  3,  0, 32'h7FF,      1, 0}; // sltiu 0x7ff
    vecs[10] = '{32'h01F11093, 3,  1,  2,  0, 32'd31,       1, 0}; // slli 31
    vecs[11] = '{32'h02011093, 0,  1,  2,  0, 32'h0,        0, 1}; // slli shamt[5]=1
    vecs[12] = '{32'h40C5F533, 0,  10, 11, 0, 32'h0,        0, 1}; // and w/ funct7 0x20
    vecs[13] = '{32'h80024193, 6,  3,  4,  0, 32'hFFFFF800, 1, 0}; // xori -2048
    vecs[14] = '{32'h0000D0B3, 7,  1,  1,  0, 32'h0,        0, 0}; // srl x1,x1,x0

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; exp_cnt = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", decode_count, 0);
    chk("rst_pc", out_pc, 0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back stream with a downstream stall on cycles 2-4
    sent = 0; got = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid  = (sent < 8);
      in_instr  = addi(sent + 1, sent);
      in_pc     = 32'h200 + 32'(sent * 4);
      out_ready = !(c >= 2 && c <= 4);
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        chk("stream_rd", out_rd, got + 1);
        chk("stream_imm", out_imm, got);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    exp_cnt = exp_cnt + 4'd8;
    chk("stream_got", got, 8);
    chk("stream_stalled", saw_stall, 1);
    chk("stream_empty", out_valid, 0);
    chk("stream_count", decode_count, exp_cnt);

    // Flush with main and skid full plus a pending input
    in_valid = 1'b1; in_instr = addi(1, 1); tick();
    in_instr = addi(2, 2); tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_main_rd", out_rd, 1);
    in_instr = addi(3, 3); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_count", decode_count, exp_cnt);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_input", out_valid, 0);
    tick();
    chk("flush_no_leak", out_valid, 0);

    // Reset while an entry is in flight
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300; tick();
    in_instr = addi(7, 7); rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 1'b0;
    exp_cnt = '0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_rd", out_rd, 0);
    chk("mid_rst_op", out_alu_op, 0);
    chk("mid_rst_count", decode_count, 0);
    tick();
    chk("mid_rst_no_leak", out_valid, 0);

    // 17 transfers on a 4-bit counter wrap it to 1
    sent = 0; got = 0; out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 17; c++) begin
      in_valid = (sent < 17);
      in_instr = addi(sent % 32, sent);
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_got", got, 17);
    chk("wrap_count", decode_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
